// File: rtl/sync_fifo_wr_arb.sv
// Round-robin, packet-locked arbiter sharing one sync_fifo write port among NUM_REQ requesters.
// Optional build macro SYNC_FIFO_WR_ARB_THRESH_EN: gate burst start on fifo_space_avail >= START_THRESH.
module sync_fifo_wr_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DATAWIDTH    = 96,
  parameter int PTRW         = 4,
  parameter int GIDW         = 2,
  parameter int START_THRESH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_eop,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_en,
  output logic [DATAWIDTH-1:0]           fifo_din,
  input  logic                           fifo_full,
  input  logic [PTRW-1:0]                fifo_space_avail,
  output logic [GIDW-1:0]                grant_id,
  output logic                           busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [PTRW-1:0] THRESH_W = PTRW'(START_THRESH);
  localparam logic [GIDW-1:0] LAST_ID  = GIDW'(NUM_REQ - 1);

  state_t                 state_r;
  logic [GIDW-1:0]        rr_ptr_r;
  logic [GIDW-1:0]        grant_r;
  logic                   busy_s;
  logic                   accept_s;
  logic                   start_s;
  logic [GIDW-1:0]        pick_s;
  logic [GIDW-1:0]        grant_inc_s;
  logic [DATAWIDTH-1:0]   slice_s [NUM_REQ];

  // First valid requester at or after ptr, wrapping at NUM_REQ (need not be a power of two).
  function automatic logic [GIDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [GIDW-1:0]    ptr);
    logic [2*NUM_REQ-1:0] dbl_v;
    logic [NUM_REQ-1:0]   rot_v;
    logic [GIDW:0]        sum_v;
    logic                 found_v;
    rr_pick = ptr;
    found_v = 1'b0;
    dbl_v   = {valid, valid} >> ptr;
    rot_v   = dbl_v[NUM_REQ-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_v = {1'b0, ptr} + (GIDW+1)'(i);
      if (sum_v >= (GIDW+1)'(NUM_REQ)) begin
        sum_v = sum_v - (GIDW+1)'(NUM_REQ);
      end
      if (!found_v && rot_v[i]) begin
        rr_pick = sum_v[GIDW-1:0];
        found_v = 1'b1;
      end
    end
  endfunction

`ifdef SYNC_FIFO_WR_ARB_THRESH_EN
  assign start_s = (|req_valid) && (fifo_space_avail >= THRESH_W);
`else
  logic unused_s;
  assign unused_s = ^{fifo_space_avail, THRESH_W};
  assign start_s  = (|req_valid) && !fifo_full;
`endif

  assign pick_s      = rr_pick(req_valid, rr_ptr_r);
  assign grant_inc_s = (grant_r == LAST_ID) ? {GIDW{1'b0}} : grant_r + GIDW'(1);
  assign busy_s      = (state_r == ST_BURST);
  assign accept_s    = busy_s && req_valid[grant_r] && !fifo_full;

  // Unpack requester beats so the data mux indexes by grant.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice_s[i] = req_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Arbitration state: grant lock, round-robin pointer and the IDLE/BURST machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= {GIDW{1'b0}};
      grant_r  <= {GIDW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            grant_r <= pick_s;
            state_r <= ST_BURST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (accept_s && req_eop[grant_r]) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= grant_inc_s;
          end else begin
            state_r  <= ST_BURST;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Write-port and handshake outputs decoded straight from the registered grant.
  always_comb begin
    req_ready  = {NUM_REQ{1'b0}};
    fifo_wr_en = 1'b0;
    if (busy_s) begin
      req_ready[grant_r] = !fifo_full;
      fifo_wr_en         = accept_s;
    end else begin
      req_ready  = {NUM_REQ{1'b0}};
      fifo_wr_en = 1'b0;
    end
  end

  assign fifo_din = slice_s[grant_r];
  assign grant_id = grant_r;
  assign busy     = busy_s;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Randomized scoreboard bench for sync_fifo_wr_arb against a packet-level reference model.
module tb_sync_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 96;
  localparam int PW = 4;
  localparam int GW = 2;
  localparam int TH = 2;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_eop;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_din;
  logic             fifo_full;
  logic [PW-1:0]    fifo_space_avail;
  logic [GW-1:0]    grant_id;
  logic             busy;

  sync_fifo_wr_arb #(.NUM_REQ(NR), .DATAWIDTH(DW), .PTRW(PW), .GIDW(GW), .START_THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_space_avail(fifo_space_avail), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard and expected per-cycle outputs
  logic [DW-1:0] exp_q[$];
  bit            in_reset;
  logic          exp_busy;
  logic          exp_wr;
  logic [NR-1:0] exp_ready;
  logic [GW-1:0] exp_gid;

  // reference model: owner = -1 when no packet is locked
  int            owner;
  int            ptr;
  int            last_gid;
  int            burst_beats;
  logic [DW-1:0] src_data[NR];
  int            src_left[NR];
  int            maxlen;
  int            vprob;
  int            fprob;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit vbit(input logic [NR-1:0] v, input int k);
    logic [GW-1:0] idx;
    idx = GW'(k);
    return v[idx];
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model. Entered at posedge+1.
  task automatic step();
    bit start_ok;
    bit eop;
    int pick;
    for (int k = 0; k < NR; k++) begin
      if (src_left[k] == 0) begin
        src_left[k] = $urandom_range(1, maxlen);
        src_data[k] = rnd_beat();
      end
      req_valid[k] = ($urandom_range(0, 99) < vprob);
      req_eop[k]   = (src_left[k] == 1);
      req_data[k*DW +: DW] = src_data[k];
    end
    fifo_full        = ($urandom_range(0, 99) < fprob);
    fifo_space_avail = fifo_full ? PW'(0) : PW'($urandom_range(1, 8));

    exp_busy  = (owner >= 0);
    exp_gid   = GW'(last_gid);
    exp_ready = '0;
    exp_wr    = 1'b0;
    if (owner >= 0 && !fifo_full) begin
      exp_ready = NR'(1) << owner;
      if (vbit(req_valid, owner)) begin
        exp_wr = 1'b1;
        exp_q.push_back(src_data[owner]);
      end
    end

`ifdef SYNC_FIFO_WR_ARB_THRESH_EN
    start_ok = (fifo_space_avail >= PW'(TH));
`else
    start_ok = !fifo_full;
`endif
    if (exp_wr) begin
      eop = (src_left[owner] == 1);
      src_left[owner]--;
      burst_beats++;
      if (src_left[owner] > 0) src_data[owner] = rnd_beat();
      if (eop) begin
        ptr   = (owner + 1) % NR;
        owner = -1;
      end
    end else if (owner < 0 && (|req_valid) && start_ok) begin
      pick = -1;
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (ptr + i) % NR;
        if (pick < 0 && vbit(req_valid, k)) pick = k;
      end
      owner       = pick;
      last_gid    = pick;
      burst_beats = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare handshake every cycle and pop the scoreboard on each push.
  always @(negedge clk) begin
    if (!in_reset) begin
      check("busy", busy, exp_busy);
      check("grant_id", grant_id, exp_gid);
      check("req_ready", req_ready, exp_ready);
      check("fifo_wr_en", fifo_wr_en, exp_wr);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          check("push_unexpected", 1'b1, 1'b0);
        end else begin
          check("fifo_din", fifo_din, exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_wr_en"}, fifo_wr_en, 1'b0);
    check({tag, "_ready"}, req_ready, '0);
    check({tag, "_gid"}, grant_id, '0);
  endtask

  task automatic reset_model();
    owner       = -1;
    ptr         = 0;
    last_gid    = 0;
    burst_beats = 0;
  endtask

  initial begin
    int guard;
    in_reset         = 1'b1;
    rst_n            = 1'b0;
    req_valid        = '0;
    req_eop          = '0;
    req_data         = '0;
    fifo_full        = 1'b0;
    fifo_space_avail = PW'(8);
    reset_model();
    for (int k = 0; k < NR; k++) begin
      src_left[k] = 0;
      src_data[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // all requesters, single-beat packets, no backpressure: 0,1,2,3,0...
    maxlen = 1; vprob = 100; fprob = 0;
    repeat (20) step();
    // multi-beat packets, no interleave
    maxlen = 3;
    repeat (40) step();
    // random valids with backpressure
    maxlen = 4; vprob = 70; fprob = 25;
    repeat (600) step();
    vprob = 40; fprob = 10;
    repeat (400) step();

    // asynchronous reset in the middle of a burst
    vprob = 80; fprob = 0;
    guard = 0;
    while (!(owner >= 0 && burst_beats >= 1 && src_left[owner] > 0) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      check("midburst_timeout", 1'b1, 1'b0);
    end else begin
      in_reset = 1'b1;
      exp_q.delete();
      req_valid = '1;
      fifo_full = 1'b0;
      fifo_space_avail = PW'(8);
      #1;
      check("pre_reset_wr_en", fifo_wr_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");
      reset_model();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_reset = 1'b0;
    end
    vprob = 100; maxlen = 2;
    repeat (20) step();
    vprob = 60; fprob = 20; maxlen = 4;
    repeat (300) step();

    @(negedge clk);
    #1;
    check("queue_drained", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
